// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the programmable sequence detector: FSM state
// encodings and the width helper used to size the history fill counter.
package fsm_seq_pkg;

  typedef enum logic {
    S_UNCFG = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Ceiling log2 (value >= 2), used as clog2(SEQ_LEN+1) so that the fill
  // counter can hold every value from 0 up to SEQ_LEN inclusive.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage : fsm_seq_pkg

// File: rtl/fsm_seq_window.sv
// History window for the sequence detector: the last SEQ_LEN accepted symbols
// (symbol 0 = oldest, in the low bits) plus a fill counter that saturates at
// SEQ_LEN. Flush clears only the fill count; window contents are left as-is
// because nothing compares against them until the window has refilled.
module fsm_seq_window
  import fsm_seq_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int SEQ_LEN = 4,
  parameter int FILL_W  = clog2(SEQ_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      shift_i,
  input  logic                      flush_i,
  input  logic [DATA_W-1:0]         data_i,
  output logic [SEQ_LEN*DATA_W-1:0] window_o,
  output logic [FILL_W-1:0]         fill_o
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

  // Shift the accepted symbol in at the newest end and track how full we are.
  // NOTE: the window is a register array, but it is still reset so that its
  // power-up contents are a defined zero rather than whatever the flops hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state is always written with <= so every flop
      // samples the pre-edge values, regardless of statement order.
      window_o <= '0;
      fill_o   <= '0;
    end else begin
      if (shift_i) begin
        window_o <= {data_i, window_o[SEQ_LEN*DATA_W-1:DATA_W]};
      end
      if (flush_i) begin
        fill_o <= '0;
      end else if (shift_i && (fill_o != FILL_MAX)) begin
        fill_o <= fill_o + 1'b1;
      end
    end
  end

endmodule : fsm_seq_window

// File: rtl/fsm_seq_detect.sv
// Runtime-programmable sequence detector with per-symbol don't-care masking,
// overlapping / non-overlapping match modes and a registered one-cycle
// found_o pulse. Optional saturating match counter enabled by defining
// FSM_SEQ_CNT_EN; without it match_cnt_o is tied to zero.
module fsm_seq_detect
  import fsm_seq_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_load_i,
  input  logic [SEQ_LEN*DATA_W-1:0] cfg_pattern_i,
  input  logic [SEQ_LEN-1:0]        cfg_mask_i,
  input  logic                      cfg_overlap_i,
  input  logic                      valid_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      cnt_clr_i,
  output logic                      armed_o,
  output logic                      found_o,
  output logic [CNT_W-1:0]          match_cnt_o
);

  localparam int FILL_W = clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);

  state_t                      state_q;
  logic [SEQ_LEN*DATA_W-1:0]   pattern_q;
  logic [SEQ_LEN-1:0]          mask_q;
  logic                        overlap_q;

  logic [SEQ_LEN*DATA_W-1:0]   window;
  logic [FILL_W-1:0]           fill;
  logic [SEQ_LEN*DATA_W-1:0]   candidate;
  logic                        accept;
  logic                        window_full_next;
  logic                        symbols_ok;
  logic                        hit;
  logic                        flush;

  // A load always wins over a coincident symbol, so acceptance excludes it.
  assign accept = (state_q == S_RUN) && valid_i && !cfg_load_i;

  // The window as it will look once the incoming symbol has been shifted in.
  assign candidate        = {data_i, window[SEQ_LEN*DATA_W-1:DATA_W]};
  assign window_full_next = (fill >= FILL_LAST);

  // Compare every unmasked candidate symbol against the latched pattern.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    symbols_ok = 1'b1;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (!mask_q[k] &&
          (candidate[k*DATA_W +: DATA_W] != pattern_q[k*DATA_W +: DATA_W])) begin
        symbols_ok = 1'b0;
      end
    end
  end

  assign hit   = accept && window_full_next && symbols_ok;
  // Non-overlap mode restarts the fill after a match; a load restarts it too.
  assign flush = cfg_load_i || (hit && !overlap_q);

  fsm_seq_window #(
    .DATA_W  (DATA_W),
    .SEQ_LEN (SEQ_LEN),
    .FILL_W  (FILL_W)
  ) u_window (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .shift_i  (accept),
    .flush_i  (flush),
    .data_i   (data_i),
    .window_o (window),
    .fill_o   (fill)
  );

  // Control FSM: configuration latching, armed flag and registered match pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_UNCFG;
      pattern_q <= '0;
      mask_q    <= '0;
      overlap_q <= 1'b0;
      armed_o   <= 1'b0;
      found_o   <= 1'b0;
    end else begin
      found_o <= hit;
      unique case (state_q)
        S_UNCFG: begin
          if (cfg_load_i) begin
            pattern_q <= cfg_pattern_i;
            mask_q    <= cfg_mask_i;
            overlap_q <= cfg_overlap_i;
            armed_o   <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (cfg_load_i) begin
            pattern_q <= cfg_pattern_i;
            mask_q    <= cfg_mask_i;
            overlap_q <= cfg_overlap_i;
          end
        end
        default: state_q <= S_UNCFG;
      endcase
    end
  end

`ifdef FSM_SEQ_CNT_EN
  // Saturating match counter; counts on the same edge that raises found_o,
  // and a clear request beats a simultaneous increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      match_cnt_o <= '0;
    end else if (hit && (match_cnt_o != {CNT_W{1'b1}})) begin
      match_cnt_o <= match_cnt_o + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign match_cnt_o    = '0;
`endif

endmodule : fsm_seq_detect

// File: tb/tb_fsm_seq_detect.sv
// Directed testbench for fsm_seq_detect (DATA_W=4, SEQ_LEN=4, CNT_W=2).
// Counter expectations follow FSM_SEQ_CNT_EN: saturating model when defined,
// constant zero otherwise.
module tb_fsm_seq_detect;

  localparam int DATA_W  = 4;
  localparam int SEQ_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      cfg_load_i;
  logic [SEQ_LEN*DATA_W-1:0] cfg_pattern_i;
  logic [SEQ_LEN-1:0]        cfg_mask_i;
  logic                      cfg_overlap_i;
  logic                      valid_i;
  logic [DATA_W-1:0]         data_i;
  logic                      cnt_clr_i;
  logic                      armed_o;
  logic                      found_o;
  logic [CNT_W-1:0]          match_cnt_o;

  int n_cmp     = 0;
  int n_err     = 0;
  int model_cnt = 0;

  fsm_seq_detect #(
    .DATA_W  (DATA_W),
    .SEQ_LEN (SEQ_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_load_i    (cfg_load_i),
    .cfg_pattern_i (cfg_pattern_i),
    .cfg_mask_i    (cfg_mask_i),
    .cfg_overlap_i (cfg_overlap_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .cnt_clr_i     (cnt_clr_i),
    .armed_o       (armed_o),
    .found_o       (found_o),
    .match_cnt_o   (match_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef FSM_SEQ_CNT_EN
    return model_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic logic [SEQ_LEN*DATA_W-1:0] pat4(input logic [3:0] s0, input logic [3:0] s1,
                                                     input logic [3:0] s2, input logic [3:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input string tag, input logic [3:0] sym, input logic exp_found);
    valid_i = 1'b1;
    data_i  = sym;
    tick();
    valid_i = 1'b0;
    if (exp_found && model_cnt < CNT_MAX) model_cnt++;
    check({tag, ".found"}, 32'(found_o), 32'(exp_found));
    check({tag, ".cnt"}, 32'(match_cnt_o), 32'(exp_cnt()));
  endtask

  task automatic load(input string tag, input logic [SEQ_LEN*DATA_W-1:0] pat,
                      input logic [SEQ_LEN-1:0] mask, input logic ov);
    cfg_load_i    = 1'b1;
    cfg_pattern_i = pat;
    cfg_mask_i    = mask;
    cfg_overlap_i = ov;
    tick();
    cfg_load_i = 1'b0;
    check({tag, ".armed"}, 32'(armed_o), 32'd1);
    check({tag, ".found"}, 32'(found_o), 32'd0);
  endtask

  task automatic clear_cnt(input string tag);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    model_cnt = 0;
    check({tag, ".cnt"}, 32'(match_cnt_o), 32'(exp_cnt()));
  endtask

  initial begin
    rst_i         = 1'b1;
    cfg_load_i    = 1'b0;
    cfg_pattern_i = '0;
    cfg_mask_i    = '0;
    cfg_overlap_i = 1'b0;
    valid_i       = 1'b0;
    data_i        = '0;
    cnt_clr_i     = 1'b0;

    // Reset held 3 cycles with random traffic, then traffic without a load.
    repeat (3) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = 4'($urandom);
      tick();
    end
    check("rst.armed", 32'(armed_o), 32'd0);
    check("rst.found", 32'(found_o), 32'd0);
    check("rst.cnt", 32'(match_cnt_o), 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = 4'($urandom);
      tick();
      check("uncfg.armed", 32'(armed_o), 32'd0);
      check("uncfg.found", 32'(found_o), 32'd0);
      check("uncfg.cnt", 32'(match_cnt_o), 32'd0);
    end
    valid_i = 1'b0;

    // Overlap: 1,2,1,2,1,2 -> pulses after 4th and 6th symbols.
    load("ovl", pat4(1, 2, 1, 2), 4'b0000, 1'b1);
    send("ovl1", 4'd1, 1'b0);
    send("ovl2", 4'd2, 1'b0);
    send("ovl3", 4'd1, 1'b0);
    send("ovl4", 4'd2, 1'b1);
    send("ovl5", 4'd1, 1'b0);
    send("ovl6", 4'd2, 1'b1);

    // Non-overlap: pulse after 4th, then 1,2 no pulse, then 1,2 pulse.
    clear_cnt("nov.clr");
    load("nov", pat4(1, 2, 1, 2), 4'b0000, 1'b0);
    send("nov1", 4'd1, 1'b0);
    send("nov2", 4'd2, 1'b0);
    send("nov3", 4'd1, 1'b0);
    send("nov4", 4'd2, 1'b1);
    send("nov5", 4'd1, 1'b0);
    send("nov6", 4'd2, 1'b0);
    send("nov7", 4'd1, 1'b0);
    send("nov8", 4'd2, 1'b1);

    // Idle cycles and masked symbol 2.
    clear_cnt("msk.clr");
    load("msk", pat4(0, 1, 2, 4), 4'b0100, 1'b1);
    send("msk1", 4'd0, 1'b0);
    send("msk2", 4'd1, 1'b0);
    repeat (3) begin
      tick();
      check("msk.idle", 32'(found_o), 32'd0);
    end
    send("msk3", 4'd7, 1'b0);
    send("msk4", 4'd4, 1'b1);

    // Load coincident with the completing symbol: load wins, history flushed.
    load("col", pat4(1, 2, 1, 2), 4'b0000, 1'b1);
    send("col1", 4'd1, 1'b0);
    send("col2", 4'd2, 1'b0);
    send("col3", 4'd1, 1'b0);
    cfg_load_i = 1'b1;
    valid_i    = 1'b1;
    data_i     = 4'd2;
    tick();
    cfg_load_i = 1'b0;
    valid_i    = 1'b0;
    check("col.found", 32'(found_o), 32'd0);
    check("col.armed", 32'(armed_o), 32'd1);
    send("col4", 4'd1, 1'b0);
    send("col5", 4'd2, 1'b0);
    send("col6", 4'd1, 1'b0);
    send("col7", 4'd2, 1'b1);

    // All-masked, overlap: 4th symbol matches, then every symbol; counter saturates.
    clear_cnt("all.clr");
    load("allo", pat4(0, 0, 0, 0), 4'b1111, 1'b1);
    send("allo1", 4'd3, 1'b0);
    send("allo2", 4'd9, 1'b0);
    send("allo3", 4'd5, 1'b0);
    for (int i = 0; i < 5; i++) send("allo.m", 4'(i), 1'b1);
    // Clear together with a match: clear wins.
    cnt_clr_i = 1'b1;
    valid_i   = 1'b1;
    data_i    = 4'hf;
    tick();
    cnt_clr_i = 1'b0;
    valid_i   = 1'b0;
    model_cnt = 0;
    check("clrhit.found", 32'(found_o), 32'd1);
    check("clrhit.cnt", 32'(match_cnt_o), 32'(exp_cnt()));
    tick();
    check("clrhit.found2", 32'(found_o), 32'd0);
    check("clrhit.cnt2", 32'(match_cnt_o), 32'(exp_cnt()));

    // All-masked, non-overlap: every 4th symbol; load keeps the count.
    load("alln", pat4(0, 0, 0, 0), 4'b1111, 1'b0);
    check("alln.cntkeep", 32'(match_cnt_o), 32'(exp_cnt()));
    for (int r = 0; r < 2; r++) begin
      send("alln.a", 4'd1, 1'b0);
      send("alln.b", 4'd2, 1'b0);
      send("alln.c", 4'd3, 1'b0);
      send("alln.d", 4'd4, 1'b1);
    end

    // Reset mid-operation coincident with a completing symbol.
    load("mrst", pat4(1, 2, 1, 2), 4'b0000, 1'b1);
    send("mrst1", 4'd1, 1'b0);
    send("mrst2", 4'd2, 1'b0);
    send("mrst3", 4'd1, 1'b0);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 4'd2;
    tick();
    valid_i   = 1'b0;
    rst_i     = 1'b0;
    model_cnt = 0;
    check("mrst.found", 32'(found_o), 32'd0);
    check("mrst.armed", 32'(armed_o), 32'd0);
    check("mrst.cnt", 32'(match_cnt_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send("mrst.ign", (i % 2 == 0) ? 4'd1 : 4'd2, 1'b0);
      check("mrst.armed2", 32'(armed_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fsm_seq_detect
